// File: rtl/igbt_charge_ctrl.sv
// igbt_charge_ctrl: per-channel capacitor charge FSMs with timeout, driver fault lockout and driver reset pulse
module igbt_charge_ctrl #(
  parameter int CH_NUM        = 3,
  parameter int TICK_DIV      = 50,
  parameter int TIMEOUT_US    = 1000,
  parameter int RST_PULSE_CYC = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [CH_NUM-1:0]     key_push,
  input  logic [CH_NUM-1:0]     voltage_cap_flag,
  input  logic [CH_NUM-1:0]     fault_igbt_driver,
  input  logic [CH_NUM-1:0]     error_igbt_driver,
  input  logic [CH_NUM-1:0]     clr_fault,
  input  logic                  abort,
  output logic [CH_NUM-1:0]     igbt_on_en,
  output logic [CH_NUM-1:0]     reset_igbt_driver,
  output logic [CH_NUM-1:0]     charge_done,
  output logic [CH_NUM-1:0]     fault_flag,
  output logic [2*CH_NUM-1:0]   fault_cause
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int RW = RST_PULSE_CYC > 1 ? $clog2(RST_PULSE_CYC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [23:0]   T_LAST   = 24'(TIMEOUT_US - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_PULSE_CYC - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_CHARGE = 2'd1, S_FAULT = 2'd2, S_DRV_RST = 2'd3;
  logic [PW-1:0]     r_pre;
  logic              r_arm;
  logic [CH_NUM-1:0] r_key_d;
  logic              w_tick;
  logic [CH_NUM-1:0] w_key_edge;
  assign w_tick = r_pre == PRE_LAST;
  // r_arm masks the first cycle after reset so a key held through reset is not seen as an edge
  assign w_key_edge = key_push & ~r_key_d & {CH_NUM{r_arm}};
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      r_pre   <= '0;
      r_arm   <= 1'b0;
      r_key_d <= '0;
    end else begin
      r_pre   <= w_tick ? '0 : r_pre + 1'b1;
      r_arm   <= 1'b1;
      r_key_d <= key_push;
    end
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic [1:0]    r_state;
    logic [23:0]   r_timer;
    logic [RW-1:0] r_rcnt;
    logic [1:0]    r_cause;
    logic          r_done;
    logic          w_drv_bad;
    assign w_drv_bad = fault_igbt_driver[g] | error_igbt_driver[g];
    always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
        r_state <= S_IDLE;
        r_timer <= '0;
        r_rcnt  <= '0;
        r_cause <= 2'b00;
        r_done  <= 1'b0;
      end else begin
        r_done <= 1'b0;
        if (r_state == S_IDLE) begin
          if (w_drv_bad) begin
            r_state <= S_FAULT;
            r_cause <= fault_igbt_driver[g] ? 2'b01 : 2'b10;
          end else if (w_key_edge[g] & voltage_cap_flag[g]) r_done <= 1'b1;
          else if (w_key_edge[g] & ~abort) begin
            r_state <= S_CHARGE;
            r_timer <= '0;
          end
        end else if (r_state == S_CHARGE) begin
          if (w_drv_bad) begin
            r_state <= S_FAULT;
            r_cause <= fault_igbt_driver[g] ? 2'b01 : 2'b10;
          end else if (abort) r_state <= S_IDLE;
          else if (voltage_cap_flag[g]) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (w_tick) begin
            // fault on the tick that would bring the timer to TIMEOUT_US
            if (r_timer == T_LAST) begin
              r_state <= S_FAULT;
              r_cause <= 2'b11;
            end else r_timer <= r_timer + 24'd1;
          end
        end else if (r_state == S_FAULT) begin
          if (clr_fault[g] & ~w_drv_bad) begin
            r_state <= S_DRV_RST;
            r_rcnt  <= '0;
          end
        end else if (r_rcnt == RST_LAST) begin
          r_state <= S_IDLE;
          r_cause <= 2'b00;
        end else r_rcnt <= r_rcnt + 1'b1;
      end
    assign igbt_on_en[g]          = r_state == S_CHARGE;
    assign reset_igbt_driver[g]   = r_state == S_DRV_RST;
    assign fault_flag[g]          = r_state == S_FAULT || r_state == S_DRV_RST;
    assign charge_done[g]         = r_done;
    assign fault_cause[2*g +: 2]  = r_cause;
  end
endmodule

// File: tb/tb_igbt_charge_ctrl.sv
// tb_igbt_charge_ctrl: directed and randomized checks of igbt_charge_ctrl against expectations built from channel-level rules
module tb_igbt_charge_ctrl;
  localparam int CH = 3, TD = 50, TO = 1000, RP = 8;
  logic clk = 1'b0, rst = 1'b1, abort = 1'b0;
  logic [CH-1:0] key = '0, vf = '0, flt = '0, err = '0, clr = '0;
  logic [CH-1:0] on, drst, done, ff;
  logic [2*CH-1:0] cause;
  int n_pass = 0, n_chk = 0, n_fail = 0;
  igbt_charge_ctrl #(.CH_NUM(CH), .TICK_DIV(TD), .TIMEOUT_US(TO), .RST_PULSE_CYC(RP)) dut (
    .sys_clk(clk), .sys_rst(rst), .key_push(key), .voltage_cap_flag(vf),
    .fault_igbt_driver(flt), .error_igbt_driver(err), .clr_fault(clr), .abort(abort),
    .igbt_on_en(on), .reset_igbt_driver(drst), .charge_done(done),
    .fault_flag(ff), .fault_cause(cause));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    int n, hi;
    logic [CH-1:0] m, f;
    #23;
    chk("rst_on", 32'(on), 0);
    chk("rst_outs", 32'({drst, done, ff, cause}), 0);
    step(1);
    rst = 1'b0;
    step(2);
    // normal charge on ch0, voltage reached after ~200 cycles
    key[0] = 1'b1;
    step(1);
    chk("c0_rise", 32'(on), 32'b001);
    step(199);
    chk("c0_hold", 32'(on), 32'b001);
    vf[0] = 1'b1;
    step(1);
    chk("c0_fall", 32'(on), 0);
    chk("c0_done", 32'(done), 32'b001);
    step(1);
    chk("c0_done_once", 32'(done), 0);
    key[0] = 1'b0;
    step(2);
    // press while already charged: done only
    key[0] = 1'b1;
    step(1);
    chk("pre_on", 32'(on), 0);
    chk("pre_done", 32'(done), 32'b001);
    step(1);
    chk("pre_done_once", 32'({on, done}), 0);
    key[0] = 1'b0;
    vf = '0;
    step(2);
    // global abort
    key = '1;
    step(1);
    chk("ab_rise", 32'(on), 32'b111);
    step($urandom_range(5, 60));
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("ab_fall", 32'(on), 0);
    chk("ab_nodone", 32'(done), 0);
    step(1);
    chk("ab_idle", 32'({on, done, ff}), 0);
    key = '0;
    step(1);
    // fault + error same cycle on ch2: cause 01 wins
    key[2] = 1'b1;
    step(3);
    flt[2] = 1'b1;
    err[2] = 1'b1;
    step(1);
    chk("f2_on", 32'(on[2]), 0);
    chk("f2_flag", 32'(ff), 32'b100);
    chk("f2_cause", 32'(cause[5:4]), 32'b01);
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0;
    step(3);
    chk("f2_clr_ignored", 32'({ff[2], drst[2]}), 32'b10);
    flt[2] = 1'b0;
    err[2] = 1'b0;
    key[2] = 1'b0;
    step(3);
    chk("f2_latched", 32'(cause[5:4]), 32'b01);
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0;
    hi = 0;
    for (int i = 0; i < 20 && drst[2]; i++) begin
      hi++;
      step(1);
    end
    chk("f2_rst_len", 32'(hi), RP);
    chk("f2_cleared", 32'({ff[2], cause[5:4], drst[2]}), 0);
    // driver error alone in IDLE on ch1
    err[1] = 1'b1;
    step(1);
    chk("e1_cause", 32'({ff[1], cause[3:2]}), 32'b110);
    err[1] = 1'b0;
    clr[1] = 1'b1;
    step(1);
    clr[1] = 1'b0;
    step(RP + 1);
    chk("e1_cleared", 32'({ff, cause}), 0);
    // timeout on ch1
    key[1] = 1'b1;
    step(1);
    chk("t1_rise", 32'(on), 32'b010);
    n = 0;
    while (on[1] && n < 60000) begin
      step(1);
      n++;
    end
    $display("timeout after %0d cycles", n);
    chk("t1_win", 32'(n >= (TO - 1) * TD + 1 && n <= TO * TD + 1), 1);
    chk("t1_flag", 32'(ff), 32'b010);
    chk("t1_cause", 32'(cause[3:2]), 32'b11);
    key[1] = 1'b0;
    clr[1] = 1'b1;
    step(1);
    clr[1] = 1'b0;
    step(RP + 1);
    chk("t1_cleared", 32'({ff, cause}), 0);
    // asynchronous reset mid-charge, key held through it
    key[0] = 1'b1;
    step(1);
    chk("r0_rise", 32'(on), 32'b001);
    step(10);
    #2 rst = 1'b1;
    #1 chk("r0_async", 32'(on), 0);
    step(2);
    #3 rst = 1'b0;
    step(5);
    chk("r0_held", 32'(on), 0);
    key[0] = 1'b0;
    step(1);
    key[0] = 1'b1;
    step(1);
    chk("r0_repress", 32'(on), 32'b001);
    vf[0] = 1'b1;
    step(1);
    chk("r0_done", 32'({on, done}), 32'b001);
    key = '0;
    vf = '0;
    step(2);
    // randomized charges: pressed channels charge until their flag arrives
    for (int it = 0; it < 12; it++) begin
      m = CH'($urandom);
      f = CH'($urandom);
      key = m;
      step(1);
      chk("rnd_on", 32'(on), 32'(m));
      step($urandom_range(1, 100));
      vf = f;
      step(1);
      chk("rnd_part", 32'({on, done}), 32'({m & ~f, m & f}));
      vf = '1;
      step(1);
      chk("rnd_rest", 32'({on, done}), 32'({CH'(0), m & ~f}));
      key = '0;
      vf = '0;
      step(2);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
